// File: rtl/pulse_stretch.sv
// Pulse stretcher: each accepted single-cycle event becomes a HOLD_CYCLES high window
// followed by a GAP_CYCLES forced low gap; busy-time events are queued or retrigger.
module pulse_stretch #(
   parameter int HOLD_CYCLES = 25000000,
   parameter int GAP_CYCLES  = 12500000,
   parameter int RETRIGGER   = 0,
   parameter int MAX_PENDING = 7,
   parameter int CNT_W       = 25,
   parameter int PEND_W      = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse_in,
   input  logic              enable,
   output logic              level_out,
   output logic              toggle_out,
   output logic [CNT_W-1:0]  remaining,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   // state | meaning
   // IDLE  | no window active, outputs low, remaining held at 0
   // HOLD  | high window, remaining counts down to 0
   // GAP   | forced low gap, then replay a queued event or return to IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]  HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

   state_t            state, state_n;
   logic [CNT_W-1:0]  rem_n;
   logic [PEND_W-1:0] pend_n;
   logic              tog_n;
   logic              ovf_n;
   logic              pend_inc;
   logic              pend_dec;
   logic              ev;

   assign ev = pulse_in & enable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         remaining  <= '0;
         pending    <= '0;
         toggle_out <= 1'b0;
         overflow   <= 1'b0;
         level_out  <= 1'b0;
      end else begin
         state      <= state_n;
         remaining  <= rem_n;
         pending    <= pend_n;
         toggle_out <= tog_n;
         overflow   <= ovf_n;
         level_out  <= (state_n == HOLD);
      end
   end

   always_comb begin
      state_n  = state;
      rem_n    = remaining;
      tog_n    = toggle_out;
      pend_inc = 1'b0;
      pend_dec = 1'b0;
      case (state)
         IDLE: begin
            rem_n = '0;
            if (ev) begin
               state_n = HOLD;
               rem_n   = HOLD_LD;
               tog_n   = ~toggle_out;
            end
         end
         HOLD: begin
            // A retrigger reload takes priority over the end-of-window exit.
            if (ev && RETRIGGER == 1) begin
               rem_n = HOLD_LD;
            end else if (remaining == '0) begin
               state_n = GAP;
               rem_n   = GAP_LD;
            end else begin
               rem_n = remaining - 1'b1;
            end
            pend_inc = ev && (RETRIGGER != 1);
         end
         GAP: begin
            pend_inc = ev;
            if (remaining == '0) begin
               if (enable && (pending != '0 || ev)) begin
                  state_n = HOLD;
                  rem_n   = HOLD_LD;
                  tog_n   = ~toggle_out;
                  if (pending != '0) pend_dec = 1'b1;
                  else               pend_inc = 1'b0;
               end else begin
                  state_n = IDLE;
                  rem_n   = '0;
               end
            end else begin
               rem_n = remaining - 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            rem_n   = '0;
         end
      endcase
   end

   always_comb begin
      pend_n = pending;
      ovf_n  = 1'b0;
      if (!enable) begin
         pend_n = '0;
      end else if (pend_inc && !pend_dec) begin
         if (pending == PEND_MAX) ovf_n  = 1'b1;
         else                     pend_n = pending + 1'b1;
      end else if (pend_dec && !pend_inc) begin
         pend_n = pending - 1'b1;
      end
   end

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: hand-derived per-cycle vector tables with a
// scoreboard queue, plus an asynchronous reset sequence. HOLD=4, GAP=2, MAX_PENDING=3.
module tb_pulse_stretch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pulse_in = 1'b0;
   logic       enable = 1'b1;

   logic       l0, t0, o0, l1, t1, o1;
   logic [2:0] r0, r1;
   logic [1:0] p0, p1;

   int checks = 0;
   int errors = 0;

   // packed observation: {level, toggle, remaining[2:0], pending[1:0], overflow}
   typedef struct {
      logic       p;
      logic       en;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0), .MAX_PENDING(3),
                   .CNT_W(3), .PEND_W(2)) dut_q (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .enable(enable),
      .level_out(l0), .toggle_out(t0), .remaining(r0), .pending(p0), .overflow(o0));

   pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1), .MAX_PENDING(3),
                   .CNT_W(3), .PEND_W(2)) dut_r (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .enable(enable),
      .level_out(l1), .toggle_out(t1), .remaining(r1), .pending(p1), .overflow(o1));

   function automatic logic [7:0] obs(input int sel);
      if (sel == 0) return {l0, t0, r0, p0, o0};
      else          return {l1, t1, r1, p1, o1};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got L=%b T=%b R=%0d P=%0d O=%b want L=%b T=%b R=%0d P=%0d O=%b",
                  name, act[7], act[6], act[5:3], act[2:1], act[0],
                  exp[7], exp[6], exp[5:3], exp[2:1], exp[0]);
      end
   endtask

   task automatic add(input int p, input int en, input int l, input int t,
                      input int r, input int pd, input int o);
      vec_t v;
      v.p   = p[0];
      v.en  = en[0];
      v.exp = {l[0], t[0], r[2:0], pd[1:0], o[0]};
      vecs.push_back(v);
   endtask

   task automatic run_vecs(input int sel, input string name);
      vec_t v;
      vec_t e;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         pulse_in = v.p;
         enable   = v.en;
         sb.push_back(v);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("%s[%0d]", name, i), obs(sel), e.exp);
      end
      @(negedge clk);
      pulse_in = 1'b0;
      enable   = 1'b1;
      vecs.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      pulse_in = 1'b0;
      enable   = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_single();
      add(1,1, 1,1,3,0,0); add(0,1, 1,1,2,0,0); add(0,1, 1,1,1,0,0); add(0,1, 1,1,0,0,0);
      add(0,1, 0,1,1,0,0); add(0,1, 0,1,0,0,0); add(0,1, 0,1,0,0,0); add(0,1, 0,1,0,0,0);
   endtask

   initial begin
      #2;
      check("reset_q", obs(0), 8'h00);
      check("reset_r", obs(1), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // single pulse, no retrigger
      load_single();
      run_vecs(0, "single");

      // retrigger mid-window keeps level high t1..t7
      do_reset();
      add(1,1, 1,1,3,0,0); add(0,1, 1,1,2,0,0); add(0,1, 1,1,1,0,0); add(1,1, 1,1,3,0,0);
      add(0,1, 1,1,2,0,0); add(0,1, 1,1,1,0,0); add(0,1, 1,1,0,0,0); add(0,1, 0,1,1,0,0);
      add(0,1, 0,1,0,0,0); add(0,1, 0,1,0,0,0);
      run_vecs(1, "retrig");

      // retrigger in the last HOLD cycle wins over the exit
      do_reset();
      add(1,1, 1,1,3,0,0); add(0,1, 1,1,2,0,0); add(0,1, 1,1,1,0,0); add(0,1, 1,1,0,0,0);
      add(1,1, 1,1,3,0,0); add(0,1, 1,1,2,0,0); add(0,1, 1,1,1,0,0); add(0,1, 1,1,0,0,0);
      add(0,1, 0,1,1,0,0); add(0,1, 0,1,0,0,0); add(0,1, 0,1,0,0,0);
      run_vecs(1, "retrig_last");

      // queued second event replays after the gap
      do_reset();
      add(1,1, 1,1,3,0,0); add(0,1, 1,1,2,0,0); add(1,1, 1,1,1,1,0); add(0,1, 1,1,0,1,0);
      add(0,1, 0,1,1,1,0); add(0,1, 0,1,0,1,0); add(0,1, 1,0,3,0,0); add(0,1, 1,0,2,0,0);
      add(0,1, 1,0,1,0,0); add(0,1, 1,0,0,0,0); add(0,1, 0,0,1,0,0); add(0,1, 0,0,0,0,0);
      add(0,1, 0,0,0,0,0);
      run_vecs(0, "queue");

      // held pulse saturates the queue, overflow for two cycles, four windows total
      do_reset();
      add(1,1, 1,1,3,0,0); add(1,1, 1,1,2,1,0); add(1,1, 1,1,1,2,0); add(1,1, 1,1,0,3,0);
      add(1,1, 0,1,1,3,1); add(1,1, 0,1,0,3,1); add(0,1, 1,0,3,2,0); add(0,1, 1,0,2,2,0);
      add(0,1, 1,0,1,2,0); add(0,1, 1,0,0,2,0); add(0,1, 0,0,1,2,0); add(0,1, 0,0,0,2,0);
      add(0,1, 1,1,3,1,0); add(0,1, 1,1,2,1,0); add(0,1, 1,1,1,1,0); add(0,1, 1,1,0,1,0);
      add(0,1, 0,1,1,1,0); add(0,1, 0,1,0,1,0); add(0,1, 1,0,3,0,0); add(0,1, 1,0,2,0,0);
      add(0,1, 1,0,1,0,0); add(0,1, 1,0,0,0,0); add(0,1, 0,0,1,0,0); add(0,1, 0,0,0,0,0);
      add(0,1, 0,0,0,0,0);
      run_vecs(0, "saturate");

      // event in the final GAP cycle with empty queue is consumed directly
      do_reset();
      add(1,1, 1,1,3,0,0); add(0,1, 1,1,2,0,0); add(0,1, 1,1,1,0,0); add(0,1, 1,1,0,0,0);
      add(0,1, 0,1,1,0,0); add(0,1, 0,1,0,0,0); add(1,1, 1,0,3,0,0); add(0,1, 1,0,2,0,0);
      add(0,1, 1,0,1,0,0); add(0,1, 1,0,0,0,0); add(0,1, 0,0,1,0,0); add(0,1, 0,0,0,0,0);
      add(0,1, 0,0,0,0,0);
      run_vecs(0, "gap_direct");

      // two queued events, enable dropped in GAP flushes the queue, pulses ignored
      do_reset();
      add(1,1, 1,1,3,0,0); add(1,1, 1,1,2,1,0); add(1,1, 1,1,1,2,0); add(0,1, 1,1,0,2,0);
      add(0,1, 0,1,1,2,0); add(0,0, 0,1,0,0,0); add(1,0, 0,1,0,0,0); add(1,0, 0,1,0,0,0);
      add(1,0, 0,1,0,0,0); add(0,1, 0,1,0,0,0);
      run_vecs(0, "disable");

      // asynchronous reset in the middle of HOLD, between clock edges
      do_reset();
      @(negedge clk);
      pulse_in = 1'b1;
      @(negedge clk);
      pulse_in = 1'b0;
      @(posedge clk);
      #3;
      check("pre_reset", obs(0), {1'b1, 1'b1, 3'd2, 2'd0, 1'b0});
      rst_n = 1'b0;
      #1;
      check("async_reset_q", obs(0), 8'h00);
      check("async_reset_r", obs(1), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      load_single();
      run_vecs(0, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
